// File: rtl/fetch_decode_unit_pkg.sv
// Shared constants for the multi-cycle core front end: phase codes, opcodes,
// function codes and instruction field positions.
package fetch_decode_unit_pkg;

  localparam logic [2:0] STATE_IF  = 3'd0;
  localparam logic [2:0] STATE_ID  = 3'd1;
  localparam logic [2:0] STATE_EX  = 3'd2;
  localparam logic [2:0] STATE_MEM = 3'd3;
  localparam logic [2:0] STATE_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDU  = OP_RTYPE;
  localparam logic [5:0] OP_SLT   = OP_RTYPE;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;

  localparam int REG_AW    = 5;
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int FUNC_HI   = 5;
  localparam int FUNC_LO   = 0;

  // R-type writes rd, ADDIU/LW write rt; branches and unknown opcodes write nothing.
  function automatic logic [REG_AW-1:0] dest_of(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[OPCODE_HI:OPCODE_LO];
    if (op == OP_ADDU || op == OP_SLT)
      return instr[RD_HI:RD_LO];
    else if (op == OP_ADDIU || op == OP_LW)
      return instr[RT_HI:RT_LO];
    else if (op == OP_BEQ || op == OP_BNE)
      return '0;
    else
      return '0;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port,
// index 0 hardwired to zero, synchronous clear.
module reg_file_2r1w #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NREGS];

  // NOTE: the array is cleared in reset on purpose (architectural state must be 0),
  // which builds it from flops; an array without that requirement should skip the reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end of the multi-cycle core: fetch handshake, field decode,
// operand read with writeback bypass, and the IF->ID->EX->MEM->WB phase sequence.
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 32,
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [IMEM_AW-1:0] pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [2:0]         state,
  output logic [5:0]         opcode,
  output logic [5:0]         value_function,
  output logic [15:0]        immediate_value,
  output logic [DATA_W-1:0]  rsourcev,
  output logic [DATA_W-1:0]  rtempv,
  output logic [4:0]         dest_reg,
  output logic               instr_valid
);

  logic [2:0]         state_next;
  logic [31:0]        instr_q;
  logic               req_active;
  logic [IMEM_AW-1:0] addr_q;
  logic               fetch_done;
  logic [4:0]         rs_idx;
  logic [4:0]         rt_idx;
  logic [DATA_W-1:0]  rf_a;
  logic [DATA_W-1:0]  rf_b;
  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  rt_val;

  // Once a request has been seen for a cycle, its address is frozen until data returns.
  assign imem_req   = (state == STATE_IF) && (req_active || run);
  assign imem_addr  = req_active ? addr_q : (imem_req ? pc : '0);
  assign fetch_done = imem_req && imem_rvalid;

  assign rs_idx = instr_q[RS_HI:RS_LO];
  assign rt_idx = instr_q[RT_HI:RT_LO];

  reg_file_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (REG_AW)
  ) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_idx),
    .raddr_b (rt_idx),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // A same-cycle writeback to a source register wins over the stored value.
  assign rs_val = (wb_en && rs_idx != '0 && wb_addr == rs_idx) ? wb_data : rf_a;
  assign rt_val = (wb_en && rt_idx != '0 && wb_addr == rt_idx) ? wb_data : rf_b;

  // NOTE: every output of this block gets its default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      STATE_IF:  if (fetch_done) state_next = STATE_ID;
      STATE_ID:  state_next = STATE_EX;
      STATE_EX:  state_next = STATE_MEM;
      STATE_MEM: state_next = STATE_WB;
      STATE_WB:  state_next = STATE_IF;
      default:   state_next = STATE_IF;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= STATE_IF;
      req_active      <= 1'b0;
      addr_q          <= '0;
      instr_q         <= '0;
      opcode          <= '0;
      value_function  <= '0;
      immediate_value <= '0;
      rsourcev        <= '0;
      rtempv          <= '0;
      dest_reg        <= '0;
      instr_valid     <= 1'b0;
    end else begin
      state <= state_next;

      if (fetch_done) begin
        req_active <= 1'b0;
        instr_q    <= imem_rdata;
      end else if (imem_req) begin
        req_active <= 1'b1;
        addr_q     <= imem_addr;
      end

      if (state == STATE_ID) begin
        opcode          <= instr_q[OPCODE_HI:OPCODE_LO];
        value_function  <= instr_q[FUNC_HI:FUNC_LO];
        immediate_value <= instr_q[IMM_HI:IMM_LO];
        rsourcev        <= rs_val;
        rtempv          <= rt_val;
        dest_reg        <= dest_of(instr_q);
        instr_valid     <= 1'b1;
      end else if (state >= STATE_WB) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: scoreboard of expected decode
// results pushed at fetch and popped when the decoded instruction appears.
module tb_fetch_decode_unit;

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [7:0]  rsv;
    logic [7:0]  rtv;
    logic [4:0]  dest;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [2:0]  state;
  logic [5:0]  opcode;
  logic [5:0]  value_function;
  logic [15:0] immediate_value;
  logic [7:0]  rsourcev;
  logic [7:0]  rtempv;
  logic [4:0]  dest_reg;
  logic        instr_valid;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [7:0] regs_m [32];

  always #5 clk = ~clk;

  fetch_decode_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .pc              (pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .state           (state),
    .opcode          (opcode),
    .value_function  (value_function),
    .immediate_value (immediate_value),
    .rsourcev        (rsourcev),
    .rtempv          (rtempv),
    .dest_reg        (dest_reg),
    .instr_valid     (instr_valid)
  );

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic bp_en,
                                 input logic [4:0] bp_addr, input logic [7:0] bp_data);
    exp_t m;
    logic [4:0] rs;
    logic [4:0] rt;
    rs = ins[25:21];
    rt = ins[20:16];
    m.opcode = ins[31:26];
    m.func   = ins[5:0];
    m.imm    = ins[15:0];
    m.rsv    = (rs == 5'd0) ? 8'd0 : (bp_en && bp_addr == rs) ? bp_data : regs_m[rs];
    m.rtv    = (rt == 5'd0) ? 8'd0 : (bp_en && bp_addr == rt) ? bp_data : regs_m[rt];
    case (ins[31:26])
      6'h00:        m.dest = ins[15:11];
      6'h09, 6'h23: m.dest = rt;
      default:      m.dest = 5'd0;
    endcase
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
    if (a != 5'd0) regs_m[a] = d;
  endtask

  // Runs one instruction from IF back to IF; run is dropped in WB so the FSM parks.
  task automatic issue(input logic [31:0] ins, input int waits, input logic [7:0] addr,
                       input logic bp_en, input logic [4:0] bp_addr, input logic [7:0] bp_data);
    exp_t e;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL start_state: got %0d want 0", state); end
    run = 1'b1; pc = addr; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      errors++; $display("FAIL req_issue: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, addr);
    end
    for (int i = 0; i < waits; i++) begin
      step();
      pc = addr + 8'd1 + 8'(i); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr || state !== 3'd0) begin
        errors++;
        $display("FAIL req_hold: req=%b addr=%h state=%0d want req=1 addr=%h state=0", imem_req, imem_addr, state, addr);
      end
    end
    sb.push_back(model(ins, bp_en, bp_addr, bp_data));
    imem_rvalid = 1'b1; imem_rdata = ins;
    step();
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    checks++;
    if (state !== 3'd1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL id_entry: state=%0d req=%b want state=1 req=0", state, imem_req);
    end
    wb_en = bp_en; wb_addr = bp_addr; wb_data = bp_data;
    step();
    wb_en = 1'b0;
    if (bp_en && bp_addr != 5'd0) regs_m[bp_addr] = bp_data;
    checks++;
    if (state !== 3'd2 || instr_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL ex_entry: state=%0d valid=%b sb=%0d want state=2 valid=1", state, instr_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (opcode !== e.opcode) begin errors++; $display("FAIL opcode: got %h want %h", opcode, e.opcode); end
      checks++;
      if (value_function !== e.func) begin errors++; $display("FAIL function: got %h want %h", value_function, e.func); end
      checks++;
      if (immediate_value !== e.imm) begin errors++; $display("FAIL immediate: got %h want %h", immediate_value, e.imm); end
      checks++;
      if (rsourcev !== e.rsv) begin errors++; $display("FAIL rsourcev: got %h want %h", rsourcev, e.rsv); end
      checks++;
      if (rtempv !== e.rtv) begin errors++; $display("FAIL rtempv: got %h want %h", rtempv, e.rtv); end
      checks++;
      if (dest_reg !== e.dest) begin errors++; $display("FAIL dest_reg: got %0d want %0d", dest_reg, e.dest); end
      step();
      checks++;
      if (state !== 3'd3 || dest_reg !== e.dest || rsourcev !== e.rsv || instr_valid !== 1'b1) begin
        errors++; $display("FAIL mem_hold: state=%0d dest=%0d rs=%h valid=%b", state, dest_reg, rsourcev, instr_valid);
      end
      step();
      checks++;
      if (state !== 3'd4 || instr_valid !== 1'b1) begin
        errors++; $display("FAIL wb_state: state=%0d valid=%b want 4/1", state, instr_valid);
      end
      run = 1'b0;
      step();
      checks++;
      if (state !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++; $display("FAIL park: state=%0d valid=%b req=%b want 0/0/0", state, instr_valid, imem_req);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; pc = 8'h5A; imem_rvalid = 1'b0; imem_rdata = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 32; i++) regs_m[i] = 8'd0;
    step(); step();
    rst_n = 1'b1;
    checks++;
    if (state !== 3'd0 || imem_req !== 1'b0 || imem_addr !== 8'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: state=%0d req=%b addr=%h valid=%b", state, imem_req, imem_addr, instr_valid);
    end
    checks++;
    if ({opcode, value_function, immediate_value, rsourcev, rtempv, dest_reg} !== 49'd0) begin
      errors++; $display("FAIL reset_fields: op=%h fn=%h imm=%h rs=%h rt=%h dest=%0d",
                         opcode, value_function, immediate_value, rsourcev, rtempv, dest_reg);
    end
  endtask

  task automatic test_addu();
    write_reg(5'd1, 8'd5);
    write_reg(5'd2, 8'd7);
    issue(r_type(5'd1, 5'd2, 5'd3, 6'h21), 0, 8'h04, 1'b0, 5'd0, 8'd0);
    issue(r_type(5'd2, 5'd1, 5'd9, 6'h2A), 0, 8'h08, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic test_dest_rules();
    issue(i_type(6'h09, 5'd0, 5'd4, 16'h0011), 0, 8'h0C, 1'b0, 5'd0, 8'd0);
    issue(i_type(6'h04, 5'd1, 5'd2, 16'hFFFE), 0, 8'h10, 1'b0, 5'd0, 8'd0);
    issue(i_type(6'h23, 5'd2, 5'd17, 16'h8001), 0, 8'h14, 1'b0, 5'd0, 8'd0);
    issue(i_type(6'h05, 5'd1, 5'd6, 16'h0002), 0, 8'h18, 1'b0, 5'd0, 8'd0);
    issue(i_type(6'h3F, 5'd1, 5'd6, 16'h1234), 0, 8'h1C, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic test_bypass();
    issue(r_type(5'd1, 5'd2, 5'd5, 6'h21), 0, 8'h20, 1'b1, 5'd1, 8'h2A);
    issue(r_type(5'd0, 5'd1, 5'd5, 6'h21), 0, 8'h24, 1'b1, 5'd0, 8'h55);
    issue(r_type(5'd2, 5'd1, 5'd5, 6'h21), 0, 8'h28, 1'b1, 5'd1, 8'h3C);
  endtask

  task automatic test_fetch_wait();
    issue(r_type(5'd1, 5'd2, 5'd7, 6'h21), 3, 8'h40, 1'b0, 5'd0, 8'd0);
    issue(i_type(6'h09, 5'd2, 5'd8, 16'h00F0), 1, 8'h44, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic test_reset_mid();
    run = 1'b1; pc = 8'h30; imem_rvalid = 1'b1; imem_rdata = r_type(5'd1, 5'd2, 5'd3, 6'h21); #1;
    step();
    imem_rvalid = 1'b0; run = 1'b0;
    step(); step();
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL mid_reach_mem: got %0d want 3", state); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (state !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'd0) begin
      errors++; $display("FAIL mid_reset_ctrl: state=%0d valid=%b req=%b addr=%h", state, instr_valid, imem_req, imem_addr);
    end
    checks++;
    if ({opcode, value_function, immediate_value, rsourcev, rtempv, dest_reg} !== 49'd0) begin
      errors++; $display("FAIL mid_reset_fields: op=%h fn=%h imm=%h rs=%h rt=%h dest=%0d",
                         opcode, value_function, immediate_value, rsourcev, rtempv, dest_reg);
    end
    for (int i = 0; i < 32; i++) regs_m[i] = 8'd0;
    run = 1'b1; pc = 8'h50; #1;
    step();
    rst_n = 1'b0; run = 1'b0;
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = r_type(5'd1, 5'd1, 5'd1, 6'h21);
    step(); step();
    checks++;
    if (state !== 3'd0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL stale_rvalid: state=%0d req=%b want 0/0", state, imem_req);
    end
    imem_rvalid = 1'b0;
    for (int i = 0; i < 16; i++)
      issue(r_type(5'(i), 5'(i + 16), 5'd0, 6'h21), 0, 8'(i), 1'b0, 5'd0, 8'd0);
  endtask

  task automatic test_run_gating();
    for (int i = 0; i < 3; i++) begin
      pc = 8'h60 + 8'(i);
      step();
      checks++;
      if (state !== 3'd0 || imem_req !== 1'b0) begin
        errors++; $display("FAIL parked: state=%0d req=%b want 0/0", state, imem_req);
      end
    end
    issue(i_type(6'h09, 5'd0, 5'd12, 16'h0077), 0, 8'h77, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [5];
    ops[0] = 6'h00; ops[1] = 6'h09; ops[2] = 6'h23; ops[3] = 6'h04; ops[4] = 6'h05;
    for (int i = 1; i < 8; i++) write_reg(5'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      logic        bp;
      op  = ops[$urandom_range(0, 4)];
      ins = (op == 6'h00)
            ? r_type(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(1, 31)),
                     ($urandom_range(0, 1) == 1) ? 6'h21 : 6'h2A)
            : i_type(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      bp = ($urandom_range(0, 1) == 1);
      issue(ins, $urandom_range(0, 2), 8'($urandom), bp, 5'($urandom_range(0, 7)), 8'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addu();
    test_dest_rules();
    test_bypass();
    test_fetch_wait();
    test_reset_mid();
    test_run_gating();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
